// File: rtl/pc_sequencer_if.sv
// Fetch-PC sequencer bus: hazard/EX-side controls in, fetch address,
// flush strobes and trap bookkeeping out.
interface pc_sequencer_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        trap_req;
  logic [31:0] ex_pc;
  logic [31:0] PC;
  logic        pc_valid;
  logic        flush_IF_ID;
  logic        flush_ID_EX;
  logic [31:0] epc;
  logic [1:0]  cause;

  // Pipeline side: hazard unit and EX resolver drive, fetch/pipe regs consume
  modport master (
    output stall, branch_taken, branch_target, trap_req, ex_pc,
    input  PC, pc_valid, flush_IF_ID, flush_ID_EX, epc, cause
  );

  // Sequencer side
  modport slave (
    input  stall, branch_taken, branch_target, trap_req, ex_pc,
    output PC, pc_valid, flush_IF_ID, flush_ID_EX, epc, cause
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-PC controller for the 32-bit RISC-V pipeline.
// Owns the fetch PC, picks sequential / redirect / trap next-PC, honours
// load-use stalls and raises flush strobes for IF/ID and ID/EX.
// DRAIN_CYCLES must lie in 1..15 (4-bit drain counter).
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  localparam logic [1:0] ST_BOOT       = 2'd0;
  localparam logic [1:0] ST_RUN        = 2'd1;
  localparam logic [1:0] ST_FLUSH      = 2'd2;
  localparam logic [1:0] ST_TRAP_DRAIN = 2'd3;

  localparam logic [1:0] CAUSE_NONE      = 2'd0;
  localparam logic [1:0] CAUSE_TRAP      = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'd2;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  cause_q, cause_d;
  logic [3:0]  drain_q, drain_d;

  logic        inRun;
  logic        targetMisaligned;
  logic        takeTrap;
  logic        takeMisalign;
  logic        takeBranch;
  logic [31:0] pcPlus4;

  // Decode the RUN-state redirect sources in priority order
  always_comb begin
    inRun            = (state_q == ST_RUN);
    targetMisaligned = (bus.branch_target[1:0] != 2'b00);
    takeTrap         = inRun && bus.trap_req;
    takeMisalign     = inRun && !bus.trap_req && bus.branch_taken && targetMisaligned;
    takeBranch       = inRun && !bus.trap_req && bus.branch_taken && !targetMisaligned;
    pcPlus4          = pc_q + 32'd4;
  end

  // Next-state, next-PC and trap bookkeeping
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    drain_d = drain_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (takeTrap || takeMisalign) begin
          pc_d    = TRAP_VECTOR;
          epc_d   = bus.ex_pc;
          cause_d = takeTrap ? CAUSE_TRAP : CAUSE_MISALIGN;
          drain_d = DRAIN_LOAD;
          state_d = ST_TRAP_DRAIN;
        end else if (takeBranch) begin
          pc_d    = bus.branch_target;
          state_d = ST_FLUSH;
        end else if (!bus.stall) begin
          pc_d = pcPlus4;
        end
      end

      ST_FLUSH: begin
        // EX holds a bubble here, so only the stall input matters
        if (!bus.stall) begin
          pc_d    = pcPlus4;
          state_d = ST_RUN;
        end
      end

      ST_TRAP_DRAIN: begin
        if (drain_q <= 4'd1) begin
          state_d = ST_RUN;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_BOOT;
        pc_d    = RESET_VECTOR;
      end
    endcase
  end

  // Architectural registers with immediate asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      epc_q   <= 32'd0;
      cause_q <= CAUSE_NONE;
      drain_q <= 4'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      drain_q <= drain_d;
    end
  end

  // Flush strobes and fetch-valid derived from current state and inputs
  always_comb begin
    logic flushNow;
    flushNow = 1'b0;
    case (state_q)
      ST_BOOT:       flushNow = 1'b1;
      ST_RUN:        flushNow = bus.trap_req || bus.branch_taken;
      ST_FLUSH:      flushNow = 1'b0;
      ST_TRAP_DRAIN: flushNow = 1'b1;
      default:       flushNow = 1'b1;
    endcase
    bus.flush_IF_ID = rst || flushNow;
    bus.flush_ID_EX = rst || flushNow;
    bus.pc_valid    = !rst && ((state_q == ST_RUN) || (state_q == ST_FLUSH));
  end

  assign bus.PC    = pc_q;
  assign bus.epc   = epc_q;
  assign bus.cause = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a
// randomized run, all compared against a behavioural fetch model.
module tb_pc_sequencer;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] TV    = 32'h0000_0100;
  localparam int          DRAIN = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_sequencer_if bus();

  pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: what fetch should look like, not how the RTL does it
  logic [31:0] mPc;
  logic [31:0] mEpc;
  logic [1:0]  mCause;
  bit          mBoot;
  bit          mAfterBranch;
  int          mDrainLeft;

  function automatic void modelReset();
    mPc = RV; mEpc = 32'd0; mCause = 2'd0;
    mBoot = 1'b1; mAfterBranch = 1'b0; mDrainLeft = 0;
  endfunction

  function automatic bit modelRunning();
    return !mBoot && (mDrainLeft == 0);
  endfunction

  function automatic bit expValid();
    return !rst && modelRunning();
  endfunction

  function automatic bit expFlush();
    if (rst || mBoot || mDrainLeft > 0) return 1'b1;
    if (mAfterBranch) return 1'b0;
    return bus.trap_req || bus.branch_taken;
  endfunction

  function automatic void enterTrap(input logic [1:0] why);
    mPc = TV; mEpc = bus.ex_pc; mCause = why; mDrainLeft = DRAIN;
  endfunction

  function automatic void modelStep();
    if (rst) begin
      modelReset();
    end else if (mBoot) begin
      mBoot = 1'b0;
    end else if (mDrainLeft > 0) begin
      mDrainLeft = mDrainLeft - 1;
    end else if (mAfterBranch) begin
      if (!bus.stall) begin
        mPc = mPc + 32'd4;
        mAfterBranch = 1'b0;
      end
    end else if (bus.trap_req) begin
      enterTrap(2'd1);
    end else if (bus.branch_taken && (bus.branch_target % 4 != 0)) begin
      enterTrap(2'd2);
    end else if (bus.branch_taken) begin
      mPc = bus.branch_target;
      mAfterBranch = 1'b1;
    end else if (!bus.stall) begin
      mPc = mPc + 32'd4;
    end
  endfunction

  task automatic applyIdle();
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'd0;
    bus.trap_req = 1'b0; bus.ex_pc = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic doReset();
    applyIdle();
    rst = 1'b1;
    modelReset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    applyIdle();
    rst = 1'b1;
    modelReset();
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++; if (bus.flush_IF_ID !== 1'b1 || bus.flush_ID_EX !== 1'b1) begin
        errors++; $display("[TB] FAIL rst_flush: got %b%b expected 11", bus.flush_IF_ID, bus.flush_ID_EX); end
      checks++; if (bus.PC !== RV || bus.pc_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL rst_pc: got pc=%h valid=%b expected pc=%h valid=0", bus.PC, bus.pc_valid, RV); end
      checks++; if (bus.epc !== 32'd0 || bus.cause !== 2'd0) begin
        errors++; $display("[TB] FAIL rst_trapregs: got epc=%h cause=%0d expected 0/0", bus.epc, bus.cause); end
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      checks++; if (bus.PC !== mPc) begin
        errors++; $display("[TB] FAIL boot_pc[%0d]: got %h expected %h", i, bus.PC, mPc); end
      checks++; if (bus.pc_valid !== expValid()) begin
        errors++; $display("[TB] FAIL boot_valid[%0d]: got %b expected %b", i, bus.pc_valid, expValid()); end
      checks++; if (bus.flush_IF_ID !== expFlush() || bus.flush_ID_EX !== expFlush()) begin
        errors++; $display("[TB] FAIL boot_flush[%0d]: got %b%b expected %b", i, bus.flush_IF_ID, bus.flush_ID_EX, expFlush()); end
      tick();
    end
  endtask

  task automatic test_stall();
    doReset();
    tick(); tick(); tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++; if (bus.PC !== mPc || bus.PC !== 32'd8) begin
        errors++; $display("[TB] FAIL stall_hold[%0d]: got %h expected %h", i, bus.PC, mPc); end
      checks++; if (bus.flush_IF_ID !== 1'b0 || bus.flush_ID_EX !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_noflush[%0d]: got %b%b expected 00", i, bus.flush_IF_ID, bus.flush_ID_EX); end
      tick();
    end
    bus.stall = 1'b0;
    #2;
    checks++; if (bus.PC !== mPc) begin
      errors++; $display("[TB] FAIL stall_third: got %h expected %h", bus.PC, mPc); end
    tick();
    #2;
    checks++; if (bus.PC !== mPc) begin
      errors++; $display("[TB] FAIL stall_resume: got %h expected %h", bus.PC, mPc); end
  endtask

  task automatic test_branch();
    doReset();
    repeat (5) tick();
    bus.branch_taken = 1'b1; bus.branch_target = 32'h40; bus.stall = 1'b1;
    #2;
    checks++; if (bus.PC !== 32'h10 || bus.flush_IF_ID !== expFlush() || bus.flush_ID_EX !== expFlush()) begin
      errors++; $display("[TB] FAIL br_flush: got pc=%h flush=%b%b expected pc=10 flush=%b", bus.PC, bus.flush_IF_ID, bus.flush_ID_EX, expFlush()); end
    tick();
    applyIdle();
    bus.branch_taken = 1'b1; bus.branch_target = 32'h80; bus.trap_req = 1'b1; bus.ex_pc = 32'h3C;
    #2;
    checks++; if (bus.PC !== mPc) begin
      errors++; $display("[TB] FAIL br_target: got %h expected %h", bus.PC, mPc); end
    checks++; if (bus.flush_IF_ID !== expFlush() || bus.pc_valid !== expValid()) begin
      errors++; $display("[TB] FAIL br_bubble: got flush=%b valid=%b expected %b/%b", bus.flush_IF_ID, bus.pc_valid, expFlush(), expValid()); end
    tick();
    applyIdle();
    #2;
    checks++; if (bus.PC !== mPc || bus.cause !== mCause) begin
      errors++; $display("[TB] FAIL br_after: got pc=%h cause=%0d expected pc=%h cause=%0d", bus.PC, bus.cause, mPc, mCause); end
  endtask

  task automatic test_trap();
    doReset();
    repeat (3) tick();
    bus.trap_req = 1'b1; bus.ex_pc = 32'h24;
    #2;
    checks++; if (bus.flush_IF_ID !== 1'b1 || bus.flush_ID_EX !== 1'b1) begin
      errors++; $display("[TB] FAIL trap_flush: got %b%b expected 11", bus.flush_IF_ID, bus.flush_ID_EX); end
    tick();
    applyIdle();
    bus.branch_taken = 1'b1; bus.branch_target = 32'h200;
    for (int i = 0; i < DRAIN; i++) begin
      #2;
      checks++; if (bus.PC !== mPc || bus.epc !== mEpc || bus.cause !== mCause) begin
        errors++; $display("[TB] FAIL trap_regs[%0d]: got pc=%h epc=%h cause=%0d expected %h/%h/%0d", i, bus.PC, bus.epc, bus.cause, mPc, mEpc, mCause); end
      checks++; if (bus.pc_valid !== expValid() || bus.flush_ID_EX !== expFlush()) begin
        errors++; $display("[TB] FAIL trap_drain[%0d]: got valid=%b flush=%b expected %b/%b", i, bus.pc_valid, bus.flush_ID_EX, expValid(), expFlush()); end
      tick();
    end
    applyIdle();
    #2;
    checks++; if (bus.PC !== TV || bus.pc_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL trap_resume: got pc=%h valid=%b expected %h/1", bus.PC, bus.pc_valid, TV); end
    tick();
    #2;
    checks++; if (bus.PC !== mPc) begin
      errors++; $display("[TB] FAIL trap_next: got %h expected %h", bus.PC, mPc); end
  endtask

  task automatic test_misaligned();
    doReset();
    repeat (2) tick();
    bus.branch_taken = 1'b1; bus.branch_target = 32'h42; bus.ex_pc = 32'h30;
    tick();
    applyIdle();
    #2;
    checks++; if (bus.cause !== 2'd2 || bus.epc !== 32'h30 || bus.PC !== TV) begin
      errors++; $display("[TB] FAIL misalign: got cause=%0d epc=%h pc=%h expected 2/30/%h", bus.cause, bus.epc, bus.PC, TV); end
    tick(); tick();
    bus.trap_req = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h80; bus.ex_pc = 32'h50;
    tick();
    applyIdle();
    #2;
    checks++; if (bus.cause !== mCause || bus.epc !== mEpc) begin
      errors++; $display("[TB] FAIL trap_priority: got cause=%0d epc=%h expected %0d/%h", bus.cause, bus.epc, mCause, mEpc); end
  endtask

  task automatic test_wrap_async();
    doReset();
    tick();
    bus.branch_taken = 1'b1; bus.branch_target = 32'hFFFF_FFFC;
    tick();
    applyIdle();
    #2;
    checks++; if (bus.PC !== 32'hFFFF_FFFC) begin
      errors++; $display("[TB] FAIL wrap_target: got %h expected fffffffc", bus.PC); end
    tick();
    #2;
    checks++; if (bus.PC !== mPc || bus.PC !== 32'd0) begin
      errors++; $display("[TB] FAIL wrap_zero: got %h expected %h", bus.PC, mPc); end
    bus.trap_req = 1'b1; bus.ex_pc = 32'h8;
    tick();
    applyIdle();
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checks++; if (bus.PC !== RV || bus.epc !== 32'd0 || bus.cause !== 2'd0) begin
      errors++; $display("[TB] FAIL async_rst: got pc=%h epc=%h cause=%0d expected %h/0/0", bus.PC, bus.epc, bus.cause, RV); end
    checks++; if (bus.flush_IF_ID !== 1'b1 || bus.pc_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL async_rst_ctl: got flush=%b valid=%b expected 1/0", bus.flush_IF_ID, bus.pc_valid); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (bus.PC !== mPc || bus.pc_valid !== expValid()) begin
        errors++; $display("[TB] FAIL reboot[%0d]: got pc=%h valid=%b expected %h/%b", i, bus.PC, bus.pc_valid, mPc, expValid()); end
      tick();
    end
  endtask

  task automatic test_random();
    doReset();
    for (int i = 0; i < 600; i++) begin
      bus.stall         = ($urandom % 4) == 0;
      bus.branch_taken  = ($urandom % 5) == 0;
      bus.branch_target = $urandom;
      if (($urandom % 4) != 0) bus.branch_target[1:0] = 2'b00;
      bus.trap_req      = ($urandom % 12) == 0;
      bus.ex_pc         = $urandom;
      rst               = ($urandom % 90) == 0;
      if (rst) modelReset();
      #2;
      checks++; if (bus.PC !== mPc) begin
        errors++; $display("[TB] FAIL rnd_pc[%0d]: got %h expected %h", i, bus.PC, mPc); end
      checks++; if (bus.pc_valid !== expValid()) begin
        errors++; $display("[TB] FAIL rnd_valid[%0d]: got %b expected %b", i, bus.pc_valid, expValid()); end
      checks++; if (bus.flush_IF_ID !== expFlush() || bus.flush_ID_EX !== expFlush()) begin
        errors++; $display("[TB] FAIL rnd_flush[%0d]: got %b%b expected %b", i, bus.flush_IF_ID, bus.flush_ID_EX, expFlush()); end
      checks++; if (bus.epc !== mEpc || bus.cause !== mCause) begin
        errors++; $display("[TB] FAIL rnd_trap[%0d]: got epc=%h cause=%0d expected %h/%0d", i, bus.epc, bus.cause, mEpc, mCause); end
      tick();
    end
    rst = 1'b0;
    applyIdle();
  endtask

  initial begin
    applyIdle();
    rst = 1'b1;
    modelReset();
    test_reset();
    test_stall();
    test_branch();
    test_trap();
    test_misaligned();
    test_wrap_async();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
